// File: rtl/fp_add_normalizer.sv
// ---------------------------------------------------------------------------
// fp_add_normalizer
//
// The FP32 adder stage that sits after the operand preparer. It adds the two
// aligned, sign-prepared 50-bit mantissas and normalizes the sum one bit per
// cycle. It then rounds to nearest-even and packs the IEEE-754
// single-precision result. Both sides use a valid/ready handshake, and only
// one operation is in flight at a time.
//
// Ports:
//   clk        in   1   single clock, all state changes on the rising edge
//   rst        in   1   synchronous active-high reset
//   in_valid   in   1   preparer outputs are valid
//   in_ready   out  1   block can accept a new operation (IDLE only)
//   NaN_res    in   1   result is NaN (has priority over inf_res)
//   inf_res    in   1   result is infinity
//   res_sig    in   1   result sign
//   exp_max    in   8   larger biased exponent of the operands
//   mant_op_1  in  50   aligned, sign-prepared mantissa 1
//   mant_op_2  in  50   aligned, sign-prepared mantissa 2
//                       (bit 49 sign guard, bit 48 carry headroom,
//                        bit 47 hidden bit, bits 23:0 guard/sticky)
//   out_valid  out  1   result is valid (DONE only)
//   out_ready  in   1   consumer accepts the result
//   result     out 32   packed FP32 result
//   ovf        out  1   finite inputs overflowed to infinity
//   inexact    out  1   rounding discarded nonzero bits
// ---------------------------------------------------------------------------
module fp_add_normalizer (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        NaN_res,
  input  logic        inf_res,
  input  logic        res_sig,
  input  logic [7:0]  exp_max,
  input  logic [49:0] mant_op_1,
  input  logic [49:0] mant_op_2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        ovf,
  output logic        inexact
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] QNAN_WORD = 32'h7FC0_0000;

  state_t      state;
  logic [49:0] acc;
  logic [9:0]  e;
  logic        sticky;
  logic        sign;

  // Operand capture values
  logic [49:0] mant_sum;
  logic [9:0]  e_start;

  // Normalization decode
  logic        acc_zero;
  logic        acc_carry;
  logic        acc_normal;

  // Rounding datapath
  logic        rnd_lsb;
  logic        rnd_guard;
  logic        rnd_sticky;
  logic        rnd_inc;
  logic [24:0] m_sum;
  logic [23:0] m_norm;
  logic [9:0]  e_rnd;
  logic [7:0]  exp_field;
  logic        rnd_ovf;

  // Handshake flags come straight from the state register, so there is no
  // combinational path from in_valid or out_ready.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // A zero exponent (denormal operands) uses the same scale as exponent 1.
  // The sum wraps modulo 2^50, which yields the magnitude directly.
  always_comb begin
    mant_sum = mant_op_1 + mant_op_2;
    e_start  = (exp_max == 8'd0) ? 10'd1 : {2'b00, exp_max};
  end

  always_comb begin
    acc_zero   = (acc == 50'd0);
    acc_carry  = acc[48];
    acc_normal = acc[47] || (e == 10'd1);
  end

  // Round to nearest-even on the normalized accumulator. A mantissa carry
  // out of the round increment renormalizes by one position. An exponent
  // field of zero is used only when the hidden bit is still clear (a
  // denormal). acc[48] is always clear here, so m_sum cannot overflow its
  // 25 bits.
  always_comb begin
    rnd_lsb    = acc[24];
    rnd_guard  = acc[23];
    rnd_sticky = (|acc[22:0]) | sticky;
    rnd_inc    = rnd_guard & (rnd_sticky | rnd_lsb);
    m_sum      = acc[48:24] + {24'd0, rnd_inc};
    if (m_sum[24]) begin
      m_norm = m_sum[24:1];
      e_rnd  = e + 10'd1;
    end else begin
      m_norm = m_sum[23:0];
      e_rnd  = e;
    end
    exp_field = m_norm[23] ? e_rnd[7:0] : 8'd0;
    rnd_ovf   = (e_rnd >= 10'd255);
  end

  // Main controller. Reset aborts any operation in flight, and the
  // registered outputs change only when a new result is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= 50'd0;
      e       <= 10'd0;
      sticky  <= 1'b0;
      sign    <= 1'b0;
      result  <= 32'd0;
      ovf     <= 1'b0;
      inexact <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            acc    <= mant_sum;
            e      <= e_start;
            sticky <= 1'b0;
            sign   <= res_sig;
            if (NaN_res) begin
              result  <= QNAN_WORD;
              ovf     <= 1'b0;
              inexact <= 1'b0;
              state   <= DONE;
            end else if (inf_res) begin
              result  <= {res_sig, 8'hFF, 23'd0};
              ovf     <= 1'b0;
              inexact <= 1'b0;
              state   <= DONE;
            end else begin
              state <= NORM;
            end
          end
        end

        NORM: begin
          if (acc_zero) begin
            result  <= 32'd0;
            ovf     <= 1'b0;
            inexact <= 1'b0;
            state   <= DONE;
          end else if (acc_carry) begin
            acc    <= acc >> 1;
            sticky <= sticky | acc[0];
            e      <= e + 10'd1;
            state  <= ROUND;
          end else if (acc_normal) begin
            state <= ROUND;
          end else begin
            acc <= acc << 1;
            e   <= e - 10'd1;
          end
        end

        ROUND: begin
          if (rnd_ovf) begin
            result <= {sign, 8'hFF, 23'd0};
            ovf    <= 1'b1;
          end else begin
            result <= {sign, exp_field, m_norm[22:0]};
            ovf    <= 1'b0;
          end
          inexact <= rnd_guard | rnd_sticky;
          state   <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_normalizer.sv
// ---------------------------------------------------------------------------
// tb_fp_add_normalizer
//
// Directed-vector bench for fp_add_normalizer. Each vector has a hand-computed
// result, flags and latency. Latency is counted in rising edges, starting at
// the edge that accepts the operands and ending at the edge after which
// out_valid is seen high. The bench also covers backpressure in DONE and a
// reset that aborts an operation during NORM.
// ---------------------------------------------------------------------------
module tb_fp_add_normalizer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        NaN_res;
  logic        inf_res;
  logic        res_sig;
  logic [7:0]  exp_max;
  logic [49:0] mant_op_1;
  logic [49:0] mant_op_2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        ovf;
  logic        inexact;

  int vectorCount;
  int miscompares;

  localparam int LAT_LIMIT = 100;

  fp_add_normalizer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .NaN_res   (NaN_res),
    .inf_res   (inf_res),
    .res_sig   (res_sig),
    .exp_max   (exp_max),
    .mant_op_1 (mant_op_1),
    .mant_op_2 (mant_op_2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .ovf       (ovf),
    .inexact   (inexact)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one operation and waits for out_valid. Returns the edge count
  // seen, or LAT_LIMIT if out_valid never rose.
  task automatic applyStimulus(input logic nan, input logic inf, input logic sgn,
                               input logic [7:0] em, input logic [49:0] m1,
                               input logic [49:0] m2, output int lat);
    bit seen;
    @(negedge clk);
    NaN_res   = nan;
    inf_res   = inf;
    res_sig   = sgn;
    exp_max   = em;
    mant_op_1 = m1;
    mant_op_2 = m2;
    in_valid  = 1'b1;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < LAT_LIMIT) begin
      @(posedge clk);
      lat++;
      #1;
      in_valid = 1'b0;
      if (out_valid) seen = 1'b1;
    end
    if (!seen) lat = LAT_LIMIT;
  endtask

  task automatic runVector(input string tag, input logic nan, input logic inf,
                           input logic sgn, input logic [7:0] em,
                           input logic [49:0] m1, input logic [49:0] m2,
                           input int expLat, input logic [31:0] expRes,
                           input logic expOvf, input logic expInx);
    int lat;
    applyStimulus(nan, inf, sgn, em, m1, m2, lat);
    checkOutput({tag, ".latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, ".result"},  64'(result), 64'(expRes));
    checkOutput({tag, ".ovf"},     64'(ovf), 64'(expOvf));
    checkOutput({tag, ".inexact"}, 64'(inexact), 64'(expInx));
    if (lat >= LAT_LIMIT) begin
      // Recover from a hung operation so that later vectors still run.
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end else begin
      // out_ready is high, so the DUT returns to IDLE on the next edge.
      @(posedge clk);
      #1;
    end
  endtask

  localparam logic [49:0] ONE      = 50'd1 << 47;
  localparam logic [49:0] MINUS1   = 50'h3_FFFF_FFFF_FFFF - ONE + 50'd1;
  localparam logic [49:0] HALF     = 50'd1 << 46;
  localparam logic [49:0] ALLONES  = 50'hFF_FFFF << 24;

  initial begin
    int lat;
    vectorCount = 0;
    miscompares = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    NaN_res   = 1'b0;
    inf_res   = 1'b0;
    res_sig   = 1'b0;
    exp_max   = 8'd0;
    mant_op_1 = 50'd0;
    mant_op_2 = 50'd0;
    out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.state", {60'd0, out_valid, in_ready, ovf, inexact}, 64'b0100);
    checkOutput("reset.result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Main function, rounding, and special cases
    runVector("one_plus_one",   0, 0, 0, 8'd127, ONE, ONE, 3, 32'h4000_0000, 0, 0);
    runVector("one_minus_one",  0, 0, 0, 8'd127, ONE, MINUS1, 2, 32'h0000_0000, 0, 0);
    runVector("cancel_k1",      0, 0, 0, 8'd127, HALF, 50'd0, 4, 32'h3F00_0000, 0, 0);
    runVector("tie_even",       0, 0, 0, 8'd127, ONE | (50'd1 << 23), 50'd0,
              3, 32'h3F80_0000, 0, 1);
    runVector("tie_odd",        0, 0, 0, 8'd127, ONE | (50'd1 << 24) | (50'd1 << 23), 50'd0,
              3, 32'h3F80_0002, 0, 1);
    runVector("nan",            1, 1, 0, 8'd127, ONE, ONE, 1, 32'h7FC0_0000, 0, 0);
    runVector("overflow",       0, 0, 0, 8'd254, ALLONES, ALLONES, 3, 32'h7F80_0000, 1, 0);
    runVector("neg_inf",        0, 1, 1, 8'd10, ONE, ONE, 1, 32'hFF80_0000, 0, 0);
    runVector("denormal",       0, 0, 0, 8'd0, HALF, 50'd0, 3, 32'h0040_0000, 0, 0);
    runVector("round_carry",    0, 0, 0, 8'd127, ALLONES | (50'd1 << 23), 50'd0,
              3, 32'h4000_0000, 0, 1);
    runVector("rshift_sticky",  0, 0, 0, 8'd127, (50'd1 << 48) | 50'd1, 50'd0,
              3, 32'h4000_0000, 0, 1);
    runVector("neg_two",        0, 0, 1, 8'd127, ONE, ONE, 3, 32'hC000_0000, 0, 0);
    runVector("max_shift",      0, 0, 0, 8'd127, 50'd1, 50'd0, 50, 32'h2800_0000, 0, 0);

    // Backpressure: the result must hold while out_ready is low
    out_ready = 1'b0;
    applyStimulus(0, 0, 0, 8'd127, ONE, ONE, lat);
    checkOutput("bp.latency", 64'(lat), 64'd3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("bp.hold", {31'd0, out_valid, in_ready, result}, {31'd0, 1'b1, 1'b0, 32'h4000_0000});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp.release", {62'd0, out_valid, in_ready}, 64'b01);

    // Reset during NORM (a 47-shift operation) aborts the operation
    @(negedge clk);
    NaN_res   = 1'b0;
    inf_res   = 1'b0;
    res_sig   = 1'b0;
    exp_max   = 8'd127;
    mant_op_1 = 50'd1;
    mant_op_2 = 50'd0;
    in_valid  = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_norm.state", {60'd0, out_valid, in_ready, ovf, inexact}, 64'b0100);
    checkOutput("rst_norm.result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    runVector("after_reset", 0, 0, 0, 8'd127, HALF, 50'd0, 4, 32'h3F00_0000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, miscompares);
    $finish;
  end

endmodule
